// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit core: clean core reset, run, halt detect, drain, done.
// Optional watchdog enabled by defining WATCHDOG_EN.
`timescale 1ns/1ps
module core_run_ctrl #(
    parameter int              PC_W         = 8,
    parameter int              IW           = 9,
    parameter logic [PC_W-1:0] LAST_PC      = 8'hFF,
    parameter logic [IW-1:0]   HALT_CODE    = 9'h1FF,
    parameter int              RST_CYCLES   = 2,
    parameter int              DRAIN_CYCLES = 1,
    parameter int              CNT_W        = 16,
    parameter int              TIMEOUT      = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic [IW-1:0]    mach_code,
    output logic             core_reset,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] RST_LAST   = WAIT_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start_q;
    logic               start_rise;
    logic               halt;
    logic               wdog_hit;
    logic [WAIT_W-1:0]  wait_cnt;

    assign start_rise = start & ~start_q;
    assign halt       = (pc == LAST_PC) | (mach_code == HALT_CODE);

`ifdef WATCHDOG_EN
    assign wdog_hit = (cycle_count == CNT_W'(TIMEOUT - 1)) & ~halt;
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_rise) state_nxt = S_RESET;
            S_RESET: if (wait_cnt == RST_LAST) state_nxt = S_RUN;
            S_RUN:   if (halt || wdog_hit) state_nxt = S_DRAIN;
            S_DRAIN: if (wait_cnt == DRAIN_LAST) state_nxt = S_DONE;
            S_DONE:  if (start_rise) state_nxt = S_RESET;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            wait_cnt    <= '0;
        end else begin
            start_q    <= start;
            core_reset <= (state_nxt == S_IDLE) || (state_nxt == S_RESET);
            core_en    <= (state_nxt == S_RUN);
            busy       <= (state_nxt == S_RESET) || (state_nxt == S_RUN) ||
                          (state_nxt == S_DRAIN);
            done       <= (state_nxt == S_DONE);

            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if ((state_nxt == S_RESET) && (state != S_RESET)) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
            end else if (state == S_RUN) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                if (wdog_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
